// File: rtl/gf2_mm_arbiter.sv
// rtl/gf2_mm_arbiter.sv - round-robin arbiter sharing one GF(2) matrix-vector multiplier
module gf2_mm_arbiter #(
  parameter int A_ROWS = 4,
  parameter int A_COLS = 8,
  parameter int N_REQ  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*A_ROWS*A_COLS-1:0]   req_a,
  input  logic [N_REQ*A_COLS-1:0]          req_b,
  output logic [N_REQ-1:0]                 rsp_valid,
  input  logic [N_REQ-1:0]                 rsp_ready,
  output logic [A_ROWS-1:0]                rsp_c,
  output logic [A_ROWS*A_COLS-1:0]         mm_a,
  output logic [A_COLS-1:0]                mm_b,
  input  logic [A_ROWS-1:0]                mm_c,
  output logic                             busy
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int ASZ = A_ROWS * A_COLS;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   idx;
  logic             any_valid;
  logic [ASZ-1:0]   sel_a;
  logic [A_COLS-1:0] sel_b;

  // Round-robin search: walk offsets from the far end so the requester closest to rr_ptr wins.
  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      idx = IDW'((int'(rr_ptr) + j) % N_REQ);
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

  // Operand mux for the winning requester, using constant slices only.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a = req_a[i*ASZ +: ASZ];
        sel_b = req_b[i*A_COLS +: A_COLS];
      end
    end
  end

  // Accept strobe: only ever offered while idle, to the single round-robin winner.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Operation sequencer: latch operands, wait out the multiplier latency, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      mm_a      <= '0;
      mm_b      <= '0;
      rsp_c     <= '0;
      rsp_valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            mm_a   <= sel_a;
            mm_b   <= sel_b;
            gnt_id <= grant;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPT;
        end
        CAPT: begin
          rsp_c             <= mm_c;
          rsp_valid         <= '0;
          rsp_valid[gnt_id] <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt_id]) begin
            rsp_valid <= '0;
            rr_ptr    <= (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_mm_arbiter.sv
// tb/tb_gf2_mm_arbiter.sv - directed and random checks of gf2_mm_arbiter with a behavioural multiplier
module tb_gf2_mm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [3:0]  rsp_c;
  logic [31:0] mm_a;
  logic [7:0]  mm_b;
  logic [3:0]  mm_c;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A0 = 32'h1234_5678;
  localparam logic [7:0]  B0 = 8'hFF;
  localparam logic [3:0]  C0 = 4'b0100;
  localparam logic [31:0] A1 = 32'h8000_00FF;
  localparam logic [7:0]  B1 = 8'h81;
  localparam logic [3:0]  C1 = 4'b1000;

  gf2_mm_arbiter #(.A_ROWS(4), .A_COLS(8), .N_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_c      (mm_c),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_mul(input logic [31:0] a, input logic [7:0] b);
    logic [3:0] c;
    for (int r = 0; r < 4; r++) c[r] = ^(a[r*8 +: 8] & b);
    return c;
  endfunction

  // Shared multiplier: one-cycle registered latency, reset tied to rst.
  always @(posedge clk) begin
    if (rst) mm_c <= 4'b0;
    else     mm_c <= ref_mul(mm_a, mm_b);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic serve(input int g, input logic [3:0] exp_c, input logic [1:0] raise,
                       input logic [1:0] drop, input string tag);
    int n;
    logic [1:0] exp_oh;
    exp_oh = 2'(1 << g);
    n = 0;
    #1;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_rdy"}, 32'(req_ready), 32'(exp_oh));
    @(negedge clk);
    req_valid = (req_valid | raise) & ~drop;
    wait_rsp();
    check_eq({tag, "_vld"}, 32'(rsp_valid), 32'(exp_oh));
    check_eq({tag, "_c"}, 32'(rsp_c), 32'(exp_c));
    rsp_ready = exp_oh;
    @(negedge clk);
    rsp_ready = 2'b00;
    check_eq({tag, "_done"}, 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    logic        seen;
    int          rr;
    int          win;
    logic [1:0]  mask;
    logic [31:0] ra0, ra1;
    logic [7:0]  rb0, rb1;

    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_c", 32'(rsp_c), 32'h0);
    check_eq("rst_mm_a", mm_a, 32'h0);
    check_eq("rst_mm_b", 32'(mm_b), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Single op on requester 0 with cycle-exact latency.
    req_a[31:0] = 32'h0F0F_FF01;
    req_b[7:0]  = 8'h03;
    req_valid   = 2'b01;
    #1 check_eq("t1_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    check_eq("t1_busy", 32'(busy), 32'h1);
    check_eq("t1_mm_a", mm_a, 32'h0F0F_FF01);
    check_eq("t1_mm_b", 32'(mm_b), 32'h03);
    check_eq("t1_vld_issue", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check_eq("t1_vld_capt", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check_eq("t1_vld", 32'(rsp_valid), 32'h1);
    check_eq("t1_c", 32'(rsp_c), 32'h1);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    check_eq("t1_done", 32'(rsp_valid), 32'h0);
    check_eq("t1_idle", 32'(busy), 32'h0);

    // Simultaneous requests after reset: 0 first, then 1 right after the handshake.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_a     = {A1, A0};
    req_b     = {B1, B0};
    req_valid = 2'b11;
    #1 check_eq("t2_ready0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b10;
    check_eq("t2_ready_busy", 32'(req_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_eq("t2_vld0", 32'(rsp_valid), 32'h1);
    check_eq("t2_c0", 32'(rsp_c), 32'(C0));
    rsp_ready = 2'b11;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check_eq("t2_ready1", 32'(req_ready), 32'h2);
    check_eq("t2_vld_drop", 32'(rsp_valid), 32'h0);
    serve(1, C1, 2'b00, 2'b10, "t2_r1");

    // Fairness: requester 0 always valid, requester 1 pulsed during each op of 0.
    req_valid = 2'b01;
    serve(0, C0, 2'b10, 2'b00, "f0");
    serve(1, C1, 2'b00, 2'b10, "f1");
    serve(0, C0, 2'b10, 2'b00, "f2");
    serve(1, C1, 2'b00, 2'b10, "f3");
    req_valid = 2'b00;

    // Backpressure on requester 0's response while requester 1 waits.
    req_valid = 2'b11;
    #1 check_eq("t4_ready0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b10;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_hold_vld", 32'(rsp_valid), 32'h1);
      check_eq("t4_hold_c", 32'(rsp_c), 32'(C0));
      check_eq("t4_hold_ready", 32'(req_ready), 32'h0);
      rsp_ready = 2'b10;
      @(negedge clk);
    end
    check_eq("t4_still_vld", 32'(rsp_valid), 32'h1);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check_eq("t4_released", 32'(rsp_valid), 32'h0);
    check_eq("t4_ready1", 32'(req_ready), 32'h2);
    serve(1, C1, 2'b00, 2'b10, "t4_r1");

    // Reset during CAPT discards the op and returns rr_ptr to 0.
    req_valid = 2'b01;
    serve(0, C0, 2'b00, 2'b01, "t5_pre");
    req_valid = 2'b01;
    #1 check_eq("t5_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    check_eq("t5_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_vld", 32'(rsp_valid), 32'h0);
    check_eq("t5_c", 32'(rsp_c), 32'h0);
    check_eq("t5_busy_clr", 32'(busy), 32'h0);
    check_eq("t5_mm_a", mm_a, 32'h0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    check_eq("t5_no_rsp", 32'(seen), 32'h0);
    req_valid = 2'b11;
    #1 check_eq("t5_rr_reset", 32'(req_ready), 32'h1);
    serve(0, C0, 2'b00, 2'b01, "t5_r0");
    serve(1, C1, 2'b00, 2'b10, "t5_r1");

    // Random operands and request patterns against the reference multiply.
    rr = 0;
    for (int k = 0; k < 12; k++) begin
      mask = 2'($urandom_range(1, 3));
      ra0  = $urandom;
      ra1  = $urandom;
      rb0  = 8'($urandom);
      rb1  = 8'($urandom);
      req_a     = {ra1, ra0};
      req_b     = {rb1, rb0};
      req_valid = mask;
      win = mask[rr] ? rr : 1 - rr;
      serve(win, (win == 0) ? ref_mul(ra0, rb0) : ref_mul(ra1, rb1), 2'b00, 2'b11, "rnd");
      rr = 1 - win;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
